regfile_multiport: RTL and testbench
====================================

// Module: regfile_multiport
// PURPOSE
//  Parametrised multi-port register file for the datapath: NUM_RD async read ports, NUM_WR sync write ports.
//  After reset, an init sequencer sweeps the bank one entry per cycle (stack-pointer entry preloaded), so the
//  bank maps to plain RAM. Replaces the single-write, 2-read bank in the CPU datapath.
// PARAMETERS
//  DATA_W   32    width of each register
//  DEPTH    32    number of registers (power of 2, >=2)
//  ADDR_W   5     log2(DEPTH)
//  NUM_RD   2     number of read ports (1..4)
//  NUM_WR   1     number of write ports (1..2)
//  SP_IDX   29    index preloaded with SP_INIT during init sweep
//  SP_INIT  227   stack-pointer init value; every other entry inits to 0
//  ZERO_REG 0     1: entry 0 reads 0 always, writes to it dropped
// PORTS
//  clock     in   1              single clock, rising edge
//  reset     in   1              asynchronous, active-high
//  we        in   NUM_WR         per-port write enable
//  waddr     in   NUM_WR*ADDR_W  write addresses, port k at [k*ADDR_W +: ADDR_W]
//  wdata     in   NUM_WR*DATA_W  write data, port k at [k*DATA_W +: DATA_W]
//  raddr     in   NUM_RD*ADDR_W  read addresses, packed as waddr
//  rdata     out  NUM_RD*DATA_W  read data, packed as wdata
//  ready     out  1              1 = init sweep complete, bank usable
// BEHAVIOUR
//  - Reset: async assert -> state=INIT, init_cnt=0, ready=0 immediately; bank contents not touched by reset.
//  - FSM: INIT -> RUN when init_cnt==DEPTH-1 is written; RUN -> INIT only via reset. No other states.
//  - INIT: each clock writes bank[init_cnt] = (init_cnt==SP_IDX) ? SP_INIT : 0, init_cnt++.
//    ready rises on the edge that writes entry DEPTH-1: exactly DEPTH clocks after reset deasserts.
//  - During INIT: we[] ignored (writes dropped, not queued); rdata all zeros.
//  - RUN: on rising edge, for each k with we[k]: bank[waddr_k] <= wdata_k.
//  - Write collision (NUM_WR=2, same address, both enabled): port 1 wins; port 0 data lost.
//  - ZERO_REG=1: writes to address 0 dropped; rdata for raddr 0 is 0 regardless of bank.
//  - Reads: combinational, rdata_j = bank[raddr_j]; read of entry being written same cycle returns OLD value
//    (unless WRITE_BYPASS_EN, below).
//  - Reset mid-sweep or mid-RUN: sweep restarts from entry 0; prior contents overwritten by sweep.
//  - init_cnt is ADDR_W bits; no wrap needed since FSM leaves INIT at DEPTH-1.
// CONFIGURATION
//  - Macro REGFILE_WRITE_BYPASS_EN defined: in RUN, if we[k] && waddr_k==raddr_j (and not dropped zero-reg write),
//    rdata_j = wdata_k same cycle; on collision port 1 data forwarded (matches write priority).
//  - Undefined: no forwarding; read returns pre-write contents until the next cycle.
// STRUCTURE
//  - Shared package regfile_pkg: state typedef {INIT, RUN}; default SP_IDX/SP_INIT constants.
//  - One sub-module regfile_init_seq: FSM + init_cnt, outputs init_we/init_addr/init_data/ready.
//  - Top: write mux (init vs. user ports, priority), bank array, per-port read/bypass generate loop.
// TESTING
//  1. Reset high 3 cycles, release -> ready=0 for 32 clocks, ready=1 on 32nd edge; read r29=227, r0..r28,r30,r31=0.
//  2. During INIT write r5=0xDEAD -> dropped; after ready, read r5 -> 0x00000000.
//  3. NUM_WR=2: both ports write r7 (0x11111111 / 0x22222222) same edge -> r7 reads 0x22222222.
//  4. Write r3=0xCAFEBABE while raddr0=3: bypass off -> old value 0 this cycle, 0xCAFEBABE next;
//     bypass on -> 0xCAFEBABE same cycle.
//  5. ZERO_REG=1: write r0=0xFFFFFFFF -> rdata for r0 = 0; with bypass on, also 0.
//  6. Assert reset at init_cnt=10, then in RUN after writing r1=0x55 -> ready drops at once, sweep restarts,
//     r1 reads 0 and r29 reads 227 after 32 clocks.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_INIT = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

    localparam int unsigned SP_IDX_DEF  = 29;
    localparam int unsigned SP_INIT_DEF = 227;

endpackage

// File: rtl/regfile_init_seq.sv
// Post-reset init sequencer: sweeps the bank once, preloading the stack-pointer entry,
// then holds RUN until the next reset.
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned SP_IDX  = SP_IDX_DEF,
    parameter int unsigned SP_INIT = SP_INIT_DEF
) (
    input  logic              clock,
    input  logic              reset,
    output logic              init_we_c,
    output logic [ADDR_W-1:0] init_addr,
    output logic [DATA_W-1:0] init_data_c,
    output logic              ready
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] init_cnt;
    logic [ADDR_W-1:0] init_cnt_nxt;
    logic              ready_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            ready    <= 1'b0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
            ready    <= ready_nxt;
        end
    end

    // Counter stops at the last entry; leaving INIT makes a wrap unnecessary.
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        ready_nxt    = ready;
        init_we_c    = 1'b0;
        init_data_c  = '0;
        if (state == ST_INIT) begin
            init_we_c = 1'b1;
            if (init_cnt == ADDR_W'(SP_IDX)) begin
                init_data_c = DATA_W'(SP_INIT);
            end
            if (init_cnt == ADDR_W'(DEPTH - 1)) begin
                state_nxt = ST_RUN;
                ready_nxt = 1'b1;
            end else begin
                init_cnt_nxt = init_cnt + ADDR_W'(1);
            end
        end
    end

    assign init_addr = init_cnt;

endmodule

// File: rtl/regfile_multiport.sv
// Multi-port register file: NUM_RD async read ports, NUM_WR sync write ports, swept after reset.
// Optional same-cycle write-to-read forwarding when REGFILE_WRITE_BYPASS_EN is defined.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 1,
    parameter int unsigned SP_IDX   = SP_IDX_DEF,
    parameter int unsigned SP_INIT  = SP_INIT_DEF,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic                     ready
);

    logic              init_we_c;
    logic [ADDR_W-1:0] init_addr;
    logic [DATA_W-1:0] init_data_c;

    logic [DATA_W-1:0] bank [DEPTH];
    logic [ADDR_W-1:0] wa   [NUM_WR];
    logic [DATA_W-1:0] wd   [NUM_WR];
    logic [NUM_WR-1:0] wr_ok_c;

    regfile_init_seq #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .SP_IDX  (SP_IDX),
        .SP_INIT (SP_INIT)
    ) u_init_seq (
        .clock       (clock),
        .reset       (reset),
        .init_we_c   (init_we_c),
        .init_addr   (init_addr),
        .init_data_c (init_data_c),
        .ready       (ready)
    );

    // Unpack write ports; user writes only count in RUN and never hit a hardwired zero entry.
    for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
        assign wa[k]      = waddr[k*ADDR_W +: ADDR_W];
        assign wd[k]      = wdata[k*DATA_W +: DATA_W];
        assign wr_ok_c[k] = we[k] && ready && !((ZERO_REG != 0) && (wa[k] == '0));
    end

    // Later ports overwrite earlier ones, so port 1 wins an address collision.
    always_ff @(posedge clock) begin
        if (init_we_c) begin
            bank[init_addr] <= init_data_c;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_ok_c[k]) begin
                    bank[wa[k]] <= wd[k];
                end
            end
        end
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd_c;

        assign ra = raddr[j*ADDR_W +: ADDR_W];

        always_comb begin
            rd_c = bank[ra];
`ifdef REGFILE_WRITE_BYPASS_EN
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_ok_c[k] && (wa[k] == ra)) begin
                    rd_c = wd[k];
                end
            end
`endif
            if (!ready || ((ZERO_REG != 0) && (ra == '0))) begin
                rd_c = '0;
            end
        end

        assign rdata[j*DATA_W +: DATA_W] = rd_c;
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench: two instances (1 write port / 2 write ports with zero register).
module tb_regfile_multiport;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        int          dut;
        int          port;
        logic [31:0] exp;
        string       name;
    } chk_t;

    logic clock = 1'b0;
    logic reset;

    logic [0:0]  we0;
    logic [4:0]  waddr0;
    logic [31:0] wdata0;
    logic [9:0]  raddr0;
    logic [63:0] rdata0;
    logic        ready0;

    logic [1:0]  we1;
    logic [9:0]  waddr1;
    logic [63:0] wdata1;
    logic [9:0]  raddr1;
    logic [63:0] rdata1;
    logic        ready1;

    chk_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clock = ~clock;

    regfile_multiport #(.NUM_WR(1), .ZERO_REG(0)) dut0 (
        .clock (clock), .reset (reset), .we (we0), .waddr (waddr0), .wdata (wdata0),
        .raddr (raddr0), .rdata (rdata0), .ready (ready0)
    );

    regfile_multiport #(.NUM_WR(2), .ZERO_REG(1)) dut1 (
        .clock (clock), .reset (reset), .we (we1), .waddr (waddr1), .wdata (wdata1),
        .raddr (raddr1), .rdata (rdata1), .ready (ready1)
    );

    // Monitor: drains every expectation queued during the cycle, away from the active edge.
    always @(negedge clock) begin
        chk_t        c;
        logic [31:0] act;
        while (sb.size() > 0) begin
            c = sb.pop_front();
            if (c.dut == 0) act = (c.port < 0) ? {31'd0, ready0} : rdata0[c.port*DW +: DW];
            else            act = (c.port < 0) ? {31'd0, ready1} : rdata1[c.port*DW +: DW];
            n_total++;
            if (act === c.exp) n_pass++;
            else $display("FAIL %s dut%0d port%0d: got %08h expected %08h",
                          c.name, c.dut, c.port, act, c.exp);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input int dut, input int port, input logic [31:0] exp, input string name);
        chk_t c;
        c.dut  = dut;
        c.port = port;
        c.exp  = exp;
        c.name = name;
        sb.push_back(c);
    endtask

    task automatic set_rd(input int dut, input int port, input logic [4:0] a);
        if (dut == 0) raddr0[port*AW +: AW] = a;
        else          raddr1[port*AW +: AW] = a;
    endtask

    task automatic chk_ready(input logic exp, input string name);
        chk(0, -1, {31'd0, exp}, name);
        chk(1, -1, {31'd0, exp}, name);
    endtask

    initial begin
        reset  = 1'b1;
        we0    = '0; waddr0 = '0; wdata0 = '0; raddr0 = '0;
        we1    = '0; waddr1 = '0; wdata1 = '0; raddr1 = '0;

        // Reset held for three cycles
        tick();
        chk_ready(1'b0, "rst_ready");
        ticks(2);
        reset = 1'b0;

        // Writes during the sweep are dropped (r5 already swept at edge 6)
        ticks(10);
        we0 = 1'b1;  waddr0 = 5'd5;            wdata0 = 32'h0000DEAD;
        we1 = 2'b01; waddr1 = {5'd0, 5'd5};    wdata1 = {32'd0, 32'h0000DEAD};
        tick();
        we0 = '0; we1 = '0;

        // rdata forced to zero during INIT even though r29 already holds 227
        set_rd(0, 0, 5'd29); set_rd(1, 0, 5'd29);
        ticks(20);
        chk_ready(1'b0, "init_ready_31");
        chk(0, 0, 32'd0, "init_rdata_zero");
        chk(1, 0, 32'd0, "init_rdata_zero");
        tick();
        chk_ready(1'b1, "ready_at_32");
        chk(0, 0, 32'd227, "sp_r29");
        chk(1, 0, 32'd227, "sp_r29");
        tick();

        // Full bank contents after the sweep
        for (int i = 0; i < 32; i++) begin
            set_rd(0, 0, 5'(i)); set_rd(0, 1, 5'(31 - i));
            set_rd(1, 0, 5'(i)); set_rd(1, 1, 5'(31 - i));
            chk(0, 0, (i == 29) ? 32'd227 : 32'd0, "sweep_p0");
            chk(0, 1, ((31 - i) == 29) ? 32'd227 : 32'd0, "sweep_p1");
            chk(1, 0, (i == 29) ? 32'd227 : 32'd0, "sweep_p0");
            chk(1, 1, ((31 - i) == 29) ? 32'd227 : 32'd0, "sweep_p1");
            tick();
        end

        // Same-cycle read of r3 while writing it
        set_rd(0, 0, 5'd3); set_rd(0, 1, 5'd4);
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hCAFEBABE;
        chk(0, 0, BYP ? 32'hCAFEBABE : 32'd0, "r3_same_cycle");
        chk(0, 1, 32'd0, "r4_no_forward");
        tick();
        we0 = '0;
        chk(0, 0, 32'hCAFEBABE, "r3_after");
        tick();

        // Write collision on r7: port 1 wins
        set_rd(1, 0, 5'd7);
        we1 = 2'b11; waddr1 = {5'd7, 5'd7}; wdata1 = {32'h22222222, 32'h11111111};
        chk(1, 0, BYP ? 32'h22222222 : 32'd0, "r7_collide_same");
        tick();
        we1 = '0;
        chk(1, 0, 32'h22222222, "r7_collide_after");
        tick();

        // Independent writes on both ports, then port 1 alone
        set_rd(1, 0, 5'd10); set_rd(1, 1, 5'd11);
        we1 = 2'b11; waddr1 = {5'd11, 5'd10}; wdata1 = {32'h00000011, 32'h00000010};
        tick();
        we1 = '0;
        chk(1, 0, 32'h00000010, "r10_p0_write");
        chk(1, 1, 32'h00000011, "r11_p1_write");
        tick();
        set_rd(1, 1, 5'd9);
        we1 = 2'b10; waddr1 = {5'd9, 5'd0}; wdata1 = {32'hA5A5A5A5, 32'd0};
        chk(1, 1, BYP ? 32'hA5A5A5A5 : 32'd0, "r9_same_cycle");
        tick();
        we1 = '0;
        chk(1, 1, 32'hA5A5A5A5, "r9_after");
        tick();

        // Zero register on dut1; r0 is ordinary on dut0
        set_rd(1, 0, 5'd0); set_rd(0, 0, 5'd0);
        we1 = 2'b01; waddr1 = {5'd0, 5'd0}; wdata1 = {32'd0, 32'hFFFFFFFF};
        we0 = 1'b1;  waddr0 = 5'd0;         wdata0 = 32'h12345678;
        chk(1, 0, 32'd0, "zreg_same_cycle");
        chk(0, 0, BYP ? 32'h12345678 : 32'd0, "r0_plain_same");
        tick();
        we1 = '0; we0 = '0;
        chk(1, 0, 32'd0, "zreg_after");
        chk(0, 0, 32'h12345678, "r0_plain_after");
        tick();

        // Reset in RUN after writing r1, then again mid-sweep
        we0 = 1'b1;  waddr0 = 5'd1;         wdata0 = 32'h55;
        we1 = 2'b01; waddr1 = {5'd0, 5'd1}; wdata1 = {32'd0, 32'h55};
        tick();
        we0 = '0; we1 = '0;
        set_rd(0, 0, 5'd1); set_rd(1, 0, 5'd1);
        chk(0, 0, 32'h55, "r1_written");
        chk(1, 0, 32'h55, "r1_written");
        tick();
        reset = 1'b1;
        chk_ready(1'b0, "run_reset_ready");
        chk(0, 0, 32'd0, "run_reset_rdata");
        ticks(2);
        reset = 1'b0;
        ticks(10);
        reset = 1'b1;
        chk_ready(1'b0, "sweep_reset_ready");
        tick();
        reset = 1'b0;
        ticks(31);
        chk_ready(1'b0, "resweep_ready_31");
        tick();
        chk_ready(1'b1, "resweep_ready_32");
        set_rd(0, 1, 5'd29); set_rd(1, 1, 5'd29);
        chk(0, 0, 32'd0, "r1_cleared");
        chk(1, 0, 32'd0, "r1_cleared");
        chk(0, 1, 32'd227, "r29_reloaded");
        chk(1, 1, 32'd227, "r29_reloaded");
        tick();
        set_rd(0, 0, 5'd3); set_rd(1, 0, 5'd7);
        chk(0, 0, 32'd0, "r3_cleared");
        chk(1, 0, 32'd0, "r7_cleared");
        tick();

        tick();
        n_total++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
